// File: rtl/moore_pkg.sv
// Shared constants for the Moore-machine cluster and its input-conditioning front end.
package moore_pkg;

    // Widths shared with the downstream Moore machine.
    localparam int unsigned SW_W    = 2;
    localparam int unsigned STATE_W = 3;

    // Default conditioning parameters.
    localparam int unsigned DEB_CYCLES_DEF = 16;
    localparam int unsigned AUTO_DIV_DEF   = 8;
    localparam int unsigned CNT_W_DEF      = 8;

    typedef logic [SW_W-1:0] sw_t;

    // Width of a counter that must hold values 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One-bit conditioner: 2-flop synchroniser followed by a consecutive-mismatch debounce counter.
// The debounced value only moves after DEB_CYCLES consecutive edges disagreeing with it.
module debounce_bit
    import moore_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic deb_o,
    output logic cnt_nonzero_o
);

    localparam int unsigned     CntW    = cnt_width(DEB_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

    logic            s1_q;
    logic            s2_q;
    logic            deb_q;
    logic            deb_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Count consecutive mismatches; any agreement restarts the count from zero.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (s2_q != deb_q) begin
            if (cnt_q == CntLast) begin
                deb_d = s2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Synchroniser, debounced value and counter state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign deb_o         = deb_q;
    assign cnt_nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/moore_step_ctrl.sv
// Input conditioning for the Moore machine: debounced switch vector, one-cycle step strobe
// (manual button or auto prescaler) and a wrapping strobe counter. A strobe is held back
// while either switch is mid-debounce, so the machine always steps on a settled sw vector.
module moore_step_ctrl
    import moore_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned AUTO_DIV   = AUTO_DIV_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SW_W-1:0]  sw_raw,
    input  logic             btn_step_raw,
    input  logic             run_mode,
    output logic [SW_W-1:0]  sw_out,
    output logic             ctrl_out,
    output logic [CNT_W-1:0] step_count
);

    localparam int unsigned       PreW      = cnt_width(AUTO_DIV);
    localparam logic [PreW-1:0]   PreLast   = PreW'(AUTO_DIV - 1);

    if (DEB_CYCLES < 2) begin : g_bad_deb
        $error("DEB_CYCLES must be at least 2");
    end
    if (AUTO_DIV < 2) begin : g_bad_div
        $error("AUTO_DIV must be at least 2");
    end

    sw_t             sw_deb;
    logic [SW_W-1:0] sw_busy;
    logic            btn_deb;
    logic            btn_busy_unused;

    logic            run_s1_q;
    logic            run_s2_q;
    logic            btn_prev_q;
    logic [PreW-1:0] pre_q;
    logic [PreW-1:0] pre_d;
    logic            pending_q;
    logic            pending_d;
    logic            ctrl_q;
    logic            ctrl_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic            busy;
    logic            auto_req;
    logic            btn_req;
    logic            req;
    logic            issue;

    for (genvar i = 0; i < SW_W; i++) begin : g_sw_deb
        debounce_bit #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_sw_deb (
            .clk_i         (clk),
            .rst_i         (reset),
            .raw_i         (sw_raw[i]),
            .deb_o         (sw_deb[i]),
            .cnt_nonzero_o (sw_busy[i])
        );
    end

    // The button's own debounce progress never defers a strobe.
    debounce_bit #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_deb (
        .clk_i         (clk),
        .rst_i         (reset),
        .raw_i         (btn_step_raw),
        .deb_o         (btn_deb),
        .cnt_nonzero_o (btn_busy_unused)
    );

    assign busy = |sw_busy;

    // Request sources and strobe arbitration.
    always_comb begin
        auto_req = run_s2_q && (pre_q == PreLast);
        btn_req  = btn_deb && !btn_prev_q && !run_s2_q;
        req      = auto_req || btn_req;

        pre_d = '0;
        if (run_s2_q) begin
            pre_d = auto_req ? '0 : pre_q + PreW'(1);
        end

        // ctrl_q blocks back-to-back strobes when a request lands on an issuing edge.
        issue = (pending_q || req) && !busy && !ctrl_q;

        if (issue) begin
            // The strobe consumes the older pending request; a fresh one stays queued.
            pending_d = pending_q && req;
        end else begin
            pending_d = pending_q || req;
        end

        ctrl_d  = issue;
        count_d = issue ? count_q + CNT_W'(1) : count_q;
    end

    // Run-mode synchroniser, button edge detector, prescaler and strobe state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_s1_q   <= 1'b0;
            run_s2_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            pre_q      <= '0;
            pending_q  <= 1'b0;
            ctrl_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            run_s1_q   <= run_mode;
            run_s2_q   <= run_s1_q;
            btn_prev_q <= btn_deb;
            pre_q      <= pre_d;
            pending_q  <= pending_d;
            ctrl_q     <= ctrl_d;
            count_q    <= count_d;
        end
    end

    assign sw_out     = sw_deb;
    assign ctrl_out   = ctrl_q;
    assign step_count = count_q;

endmodule
